// File: rtl/core_mem_pkg.sv
// Shared definitions for the core-side memory access path.
// Holds the RV32I size/sign codes, the load/store FSM state encoding,
// the default timeout and helpers that classify a request as illegal or
// misaligned before any memory command is issued.
package core_mem_pkg;

  // RV32I funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Cycles to wait for a done flag before giving up
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Unsigned sizes only exist for loads; anything else is not a size code
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering between the core and a word-only memory.
// Ports:
//   funct3_i     - RV32I size/sign code of the access
//   addr_lo_i    - byte offset within the word (addr[1:0])
//   word_i       - word read from memory
//   wdata_i      - right-aligned store data from the core
//   load_data_o  - selected lane of word_i, sign/zero extended
//   store_word_o - word_i with the addressed lane replaced by wdata_i
module lsu_data_align
  import core_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = word_i[7:0];
    case (addr_lo_i)
      2'd0:    byteLane = word_i[7:0];
      2'd1:    byteLane = word_i[15:8];
      2'd2:    byteLane = word_i[23:16];
      default: byteLane = word_i[31:24];
    endcase
    halfLane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_data_o = 32'd0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byteLane[7]}}, byteLane};
      F3_BU:   load_data_o = {24'd0, byteLane};
      F3_H:    load_data_o = {{16{halfLane[15]}}, halfLane};
      F3_HU:   load_data_o = {16'd0, halfLane};
      F3_W:    load_data_o = word_i;
      default: load_data_o = 32'd0;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word just read
  always_comb begin
    store_word_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        store_word_o = word_i;
        case (addr_lo_i)
          2'd0:    store_word_o[7:0]   = wdata_i[7:0];
          2'd1:    store_word_o[15:8]  = wdata_i[7:0];
          2'd2:    store_word_o[23:16] = wdata_i[7:0];
          default: store_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        store_word_o = word_i;
        if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else              store_word_o[15:0]  = wdata_i[15:0];
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Core-side initiator for a word-only memory access unit.
// Accepts one RV32I load/store at a time, issues level read/write commands,
// performs read-modify-write for sub-word stores and returns a one-cycle
// response with extended load data or an error flag.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake (ready only when idle)
//   req_we, req_funct3, req_addr,
//   req_wdata                        - request fields, stable until accepted
//   resp_valid, resp_rdata, resp_err - single-cycle response
//   ctrl_mem_read, ctrl_mem_write    - level commands to the memory unit
//   mem_address, mem_write_data      - word address and full write word
//   mem_read_data                    - read word, valid with stat_mem_read_done
//   stat_mem_read_done,
//   stat_mem_write_done              - completion flags from the memory unit
module lsu_mem_initiator
  import core_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ctrl_mem_read,
  output logic              ctrl_mem_write,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  input  logic              stat_mem_read_done,
  input  logic              stat_mem_write_done
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the cycle it sits there
  // without a done flag is the last cycle the command stays high.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic             we_q;
  logic [31:0]      wdata_q;

  logic             req_ready_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;
  logic             ctrl_rd_q;
  logic             ctrl_wr_q;
  logic [31:0]      mem_address_q;
  logic [31:0]      mem_write_data_q;

  logic             reqBad_d;
  logic             needRead_d;
  logic [31:0]      loadData;
  logic [31:0]      storeWord;

  assign reqBad_d   = f3_illegal(req_we, req_funct3) | f3_misaligned(req_funct3, req_addr[1:0]);
  // Loads and sub-word stores both start by reading the word
  assign needRead_d = !req_we || (req_funct3 != F3_W);

  lsu_data_align u_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_lo_q),
    .word_i       (mem_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (loadData),
    .store_word_o (storeWord)
  );

  // Single FSM: every output is a register updated alongside the state, so
  // commands and the response pulse change only on clock edges (or reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      funct3_q         <= 3'd0;
      addr_lo_q        <= 2'd0;
      we_q             <= 1'b0;
      wdata_q          <= 32'd0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      resp_err_q       <= 1'b0;
      ctrl_rd_q        <= 1'b0;
      ctrl_wr_q        <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            funct3_q      <= req_funct3;
            addr_lo_q     <= req_addr[1:0];
            we_q          <= req_we;
            wdata_q       <= req_wdata;
            req_ready_q   <= 1'b0;
            cnt_q         <= '0;
            mem_address_q <= 32'(req_addr >> 2);
            if (reqBad_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else if (needRead_d) begin
              state_q   <= ST_RD;
              ctrl_rd_q <= 1'b1;
            end else begin
              state_q          <= ST_WR;
              ctrl_wr_q        <= 1'b1;
              mem_write_data_q <= req_wdata;
            end
          end
        end

        ST_RD: begin
          // A done flag in the limit cycle still counts as success
          if (stat_mem_read_done) begin
            ctrl_rd_q <= 1'b0;
            if (!we_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= loadData;
            end else begin
              state_q          <= ST_WR;
              ctrl_wr_q        <= 1'b1;
              mem_write_data_q <= storeWord;
              cnt_q            <= '0;
            end
          end else if (cnt_q == CNT_LAST) begin
            ctrl_rd_q    <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WR: begin
          if (stat_mem_write_done) begin
            ctrl_wr_q    <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
          end else if (cnt_q == CNT_LAST) begin
            ctrl_wr_q    <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          ctrl_rd_q   <= 1'b0;
          ctrl_wr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign ctrl_mem_read  = ctrl_rd_q;
  assign ctrl_mem_write = ctrl_wr_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed testbench for lsu_mem_initiator with a small registered memory
// responder that answers each command one cycle after it is seen.
module tb_lsu_mem_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        stat_mem_read_done;
  logic        stat_mem_write_done;

  // Memory model state
  logic [31:0] memWords [0:15];
  logic        memEnable;
  logic        preloadEn;
  logic [3:0]  preloadAddr;
  logic [31:0] preloadData;

  // Observations gathered by applyStimulus
  int          checkCount = 0;
  int          errorCount = 0;
  int          obsLat;
  int          rdCycles;
  int          wrCycles;
  logic        bothSeen;
  logic [31:0] obsRdata;
  logic        obsErr;
  logic [31:0] rdAddr;
  logic [31:0] wrAddr;
  logic [31:0] wrData;

  lsu_mem_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_funct3          (req_funct3),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .resp_err            (resp_err),
    .ctrl_mem_read       (ctrl_mem_read),
    .ctrl_mem_write      (ctrl_mem_write),
    .mem_address         (mem_address),
    .mem_write_data      (mem_write_data),
    .mem_read_data       (mem_read_data),
    .stat_mem_read_done  (stat_mem_read_done),
    .stat_mem_write_done (stat_mem_write_done)
  );

  always #5 clk = ~clk;

  // Done flags pulse for one cycle, one cycle after the command is seen;
  // memEnable=0 models a memory that never answers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_mem_read_done  <= 1'b0;
      stat_mem_write_done <= 1'b0;
      mem_read_data       <= 32'd0;
    end else begin
      stat_mem_read_done  <= ctrl_mem_read && memEnable && !stat_mem_read_done;
      stat_mem_write_done <= ctrl_mem_write && memEnable && !stat_mem_write_done;
      mem_read_data       <= memWords[mem_address[3:0]];
    end
  end

  // Storage is written either by a preload from the bench or by the DUT
  always @(posedge clk) begin
    if (preloadEn)
      memWords[preloadAddr] <= preloadData;
    else if (ctrl_mem_write && memEnable && !stat_mem_write_done)
      memWords[mem_address[3:0]] <= mem_write_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic preloadWord(input logic [3:0] a, input logic [31:0] d);
    preloadAddr = a;
    preloadData = d;
    preloadEn   = 1'b1;
    @(posedge clk); #1;
    preloadEn   = 1'b0;
  endtask

  // Issue one request and follow it until resp_valid (bounded), then check
  // that the response pulse ends and the block is ready again.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    obsLat   = 0;
    rdCycles = 0;
    wrCycles = 0;
    bothSeen = 1'b0;
    obsRdata = 32'hxxxxxxxx;
    obsErr   = 1'bx;
    rdAddr   = 32'hffffffff;
    wrAddr   = 32'hffffffff;
    wrData   = 32'hffffffff;
    for (int i = 1; i <= 64; i++) begin
      if (ctrl_mem_read) begin
        rdCycles++;
        rdAddr = mem_address;
      end
      if (ctrl_mem_write) begin
        wrCycles++;
        wrAddr = mem_address;
        wrData = mem_write_data;
      end
      if (ctrl_mem_read && ctrl_mem_write) bothSeen = 1'b1;
      if (resp_valid) begin
        obsLat   = i;
        obsRdata = resp_rdata;
        obsErr   = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("pulse_end", {31'd0, resp_valid}, 32'd0);
    checkOutput("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    memEnable   = 1'b1;
    preloadEn   = 1'b0;
    preloadAddr = 4'd0;
    preloadData = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, still held in reset
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_rd", {31'd0, ctrl_mem_read}, 32'd0);
    checkOutput("rst_wr", {31'd0, ctrl_mem_write}, 32'd0);
    checkOutput("rst_addr", mem_address, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW at 0x10 of word 4
    preloadWord(4'd4, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
    checkOutput("lw_lat", obsLat, 32'd3);
    checkOutput("lw_rdata", obsRdata, 32'hDEADBEEF);
    checkOutput("lw_err", {31'd0, obsErr}, 32'd0);
    checkOutput("lw_addr", rdAddr, 32'd4);
    checkOutput("lw_nowr", wrCycles, 32'd0);

    // Byte and half loads with extension
    preloadWord(4'd4, 32'h80FF1234);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'd0);
    checkOutput("lb13", obsRdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'd0);
    checkOutput("lbu13", obsRdata, 32'h00000080);
    applyStimulus(1'b0, 3'b000, 32'h10, 32'd0);
    checkOutput("lb10", obsRdata, 32'h00000034);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'd0);
    checkOutput("lh12", obsRdata, 32'hFFFF80FF);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'd0);
    checkOutput("lhu12", obsRdata, 32'h000080FF);

    // SB read-modify-write
    preloadWord(4'd4, 32'h11223344);
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h000000AB);
    checkOutput("sb_lat", obsLat, 32'd5);
    checkOutput("sb_err", {31'd0, obsErr}, 32'd0);
    checkOutput("sb_rdata", obsRdata, 32'd0);
    checkOutput("sb_rdcyc", rdCycles, 32'd2);
    checkOutput("sb_wrcyc", wrCycles, 32'd2);
    checkOutput("sb_wraddr", wrAddr, 32'd4);
    checkOutput("sb_wrdata", wrData, 32'h1122AB44);
    checkOutput("sb_both", {31'd0, bothSeen}, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
    checkOutput("sb_readback", obsRdata, 32'h1122AB44);

    // SH upper half, then a plain word store and readback
    applyStimulus(1'b1, 3'b001, 32'h12, 32'hCAFEBEEF);
    checkOutput("sh_lat", obsLat, 32'd5);
    checkOutput("sh_wrdata", wrData, 32'hBEEFAB44);
    applyStimulus(1'b1, 3'b010, 32'h14, 32'h12345678);
    checkOutput("sw_lat", obsLat, 32'd3);
    checkOutput("sw_rdcyc", rdCycles, 32'd0);
    checkOutput("sw_wraddr", wrAddr, 32'd5);
    checkOutput("sw_wrdata", wrData, 32'h12345678);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'd0);
    checkOutput("sw_readback", obsRdata, 32'h12345678);

    // Misaligned and illegal requests never reach memory
    applyStimulus(1'b0, 3'b001, 32'h13, 32'd0);
    checkOutput("lh13_lat", obsLat, 32'd1);
    checkOutput("lh13_err", {31'd0, obsErr}, 32'd1);
    checkOutput("lh13_rdata", obsRdata, 32'd0);
    checkOutput("lh13_cmd", rdCycles + wrCycles, 32'd0);
    applyStimulus(1'b1, 3'b010, 32'h0E, 32'h5A5A5A5A);
    checkOutput("sw0e_lat", obsLat, 32'd1);
    checkOutput("sw0e_err", {31'd0, obsErr}, 32'd1);
    checkOutput("sw0e_cmd", rdCycles + wrCycles, 32'd0);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'd0);
    checkOutput("ld_f3_011_err", {31'd0, obsErr}, 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'd0);
    checkOutput("st_f3_100_err", {31'd0, obsErr}, 32'd1);
    checkOutput("st_f3_100_cmd", rdCycles + wrCycles, 32'd0);

    // Read timeout: memory never answers
    memEnable = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
    checkOutput("to_rdcyc", rdCycles, 32'(TO));
    checkOutput("to_lat", obsLat, 32'(TO + 1));
    checkOutput("to_err", {31'd0, obsErr}, 32'd1);
    checkOutput("to_rdata", obsRdata, 32'd0);
    memEnable = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
    checkOutput("post_to_rdata", obsRdata, 32'hBEEFAB44);
    checkOutput("post_to_err", {31'd0, obsErr}, 32'd0);

    // Reset while a word store is waiting in WR
    memEnable  = 1'b0;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h55AA55AA;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    checkOutput("wr_active", {31'd0, ctrl_mem_write}, 32'd1);
    @(posedge clk); #1;
    checkOutput("wr_still", {31'd0, ctrl_mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_drop", {31'd0, ctrl_mem_write}, 32'd0);
    checkOutput("async_noresp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rel_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rel_noresp", {31'd0, resp_valid}, 32'd0);
    memEnable = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
    checkOutput("after_rst_lat", obsLat, 32'd3);
    checkOutput("after_rst_rdata", obsRdata, 32'hBEEFAB44);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Core-side initiator of the memory-access handshake. It drives ctrl_mem_read/ctrl_mem_write toward the memory access unit and consumes stat_mem_read_done/stat_mem_write_done.
- Accepts one RV32I load/store request at a time from the execute stage. Handles byte/half/word sizing, sign/zero extension and alignment checks.
- The memory is word-only, so sub-word stores become a read-modify-write.
- Returns a single response pulse with load data or an error flag.

Parameters:
- ADDR_W, 32, byte-address width on the core side.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for a done flag before reporting an error; must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; held with its fields stable until accepted.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: response ready.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, or timeout.
- ctrl_mem_read  out  1  memory read command.
- ctrl_mem_write  out  1  memory write command.
- mem_address  out  32  word address = req_addr >> 2.
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  word returned by memory; valid in the cycle stat_mem_read_done is high.
- stat_mem_read_done  in  1  read complete.
- stat_mem_write_done  in  1  write complete.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. All outputs 0 except req_ready=1; timeout counter 0.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - addr, funct3, we and wdata are latched; req_ready drops the next cycle.
- FSM states: IDLE, RD, WR, RESP.
- IDLE on accept:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or illegal funct3 -> RESP with err=1. No memory command is issued.
  - Load, or sub-word store -> RD.
  - Word store -> WR.
- RD:
  - ctrl_mem_read=1 and mem_address held stable.
  - On stat_mem_read_done: capture mem_read_data, drop ctrl_mem_read the next cycle.
  - Load -> RESP. Sub-word store -> WR with the merged word.
- WR:
  - ctrl_mem_write=1, mem_write_data = merged word or req_wdata.
  - On stat_mem_write_done -> RESP.
- Commands are level signals: exactly one of ctrl_mem_read/ctrl_mem_write is high in RD/WR; never both.
- Done flags are ignored outside the matching state.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE with req_ready=1.
  - Minimum accept-to-resp_valid latency: load/word store 3 cycles; sub-word store 5 cycles; error 1 cycle.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- Store merge:
  - SB replaces byte addr[1:0] of the read word with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle waiting there.
  - When it reaches TIMEOUT_CYCLES with no done flag: drop the command, go to RESP with err=1, rdata=0.
  - A sub-word store that times out in RD performs no write.
- Done arriving in the same cycle the counter hits the limit: done wins, no error.
- Reset mid-operation: commands drop immediately (asynchronous); no response is issued for the aborted request.
- No request queueing; req_valid while busy is simply not accepted.

Decomposition:
- Shared package (core_mem_pkg): funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, and the TIMEOUT_CYCLES default.
- One natural sub-module, lsu_data_align: combinational load extract/extend and store merge. Inputs: funct3, addr[1:0], word, wdata.
- The FSM, counter and handshakes stay in the top module.

Test Plan:
- LW at 0x10, memory word 4 = 0xDEADBEEF -> ctrl_mem_read with mem_address=4; resp_rdata=0xDEADBEEF, err=0, resp_valid 3 cycles after accept.
- LB at 0x13 and LBU at 0x13, word 4 = 0x80FF1234 -> resp_rdata 0xFFFFFF80 and 0x00000080 respectively.
- SB 0xAB at 0x11, word 4 = 0x11223344:
  - Read issued, then write of 0x1122AB44 to address 4.
  - A following LW at 0x10 returns 0x1122AB44.
  - ctrl_mem_read and ctrl_mem_write never high together.
- LH at 0x13 and SW at 0x0E -> resp_err=1 one cycle after accept; no ctrl_mem_* activity.
- Load with stat_mem_read_done held low -> ctrl_mem_read high for exactly TIMEOUT_CYCLES cycles; then resp_valid with err=1, rdata=0; req_ready returns high.
- Assert rst_n=0 while in WR -> ctrl_mem_write falls without waiting for clk; no resp_valid; after release req_ready=1 and a new LW completes normally.
